mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of BUSY cycles to wait for memAck before aborting.
REQ-002 clk  in  1  the single clock; all state SHALL change on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 valid_EXMEM  in  1  EX/MEM slot holds a real instruction.
REQ-005 memRead_EXMEM, memWrite_EXMEM, regWrite_EXMEM, memToReg_EXMEM  in  1 each  control bits from the EX/MEM latch.
REQ-006 result_EXMEM  in  32  ALU result; this is the memory address for loads and stores.
REQ-007 writeData_EXMEM  in  32  store data (the forwarded rt value).
REQ-008 rd_EXMEM  in  5  destination register.
REQ-009 memReq  out  1  data-memory request.
REQ-010 memWe  out  1  request is a write.
REQ-011 memAddr  out  32  word address.
REQ-012 memWdata  out  32  write data.
REQ-013 memAck  in  1  memory completion; memRdata is valid in the same cycle.
REQ-014 memRdata  in  32  load data.
REQ-015 stallPipeline  out  1  upstream SHALL hold the EX/MEM contents while this signal is high.
REQ-016 regWrite_MEMWB  out  1  MEM/WB register-file write enable.
REQ-017 rd_MEMWB  out  5  MEM/WB destination register.
REQ-018 valueToWB  out  32  value fed to writeback and to the exec-stage forwarding path.
REQ-019 memFault  out  1  one-cycle pulse on a misaligned access or a timeout.

Function
REQ-020 The FSM SHALL have two states, IDLE and BUSY; a memory op is memRead_EXMEM or memWrite_EXMEM asserted with valid_EXMEM high.
REQ-021 In IDLE, an aligned memory op (result_EXMEM[1:0] == 0) SHALL have its address, data, rd and control bits latched on the edge, move the FSM to BUSY, and load a bubble into MEM/WB (regWrite_MEMWB = 0).
REQ-022 stallPipeline SHALL be combinational: (IDLE and aligned memory op) or (BUSY and not memAck and not timeout-hit).
REQ-023 In BUSY, memReq SHALL be 1 and memAddr, memWe and memWdata SHALL come from the latched values, held stable until completion; EX/MEM inputs SHALL be ignored.
REQ-024 BUSY with memAck SHALL load MEM/WB on that edge and return the FSM to IDLE, with valueToWB = memToReg ? memRdata : latched address.
REQ-025 On that same edge, regWrite_MEMWB = latched regWrite and (rd != 0).
REQ-026 Minimum load latency, from accept edge to MEM/WB valid, SHALL be 2 edges, which requires memAck in the first BUSY cycle.
REQ-027 A BUSY-cycle counter SHALL clear on entry to BUSY.
REQ-028 When the counter reaches TIMEOUT-1 without memAck: abort to IDLE, pulse memFault, load a bubble into MEM/WB, and deassert stall that cycle.
REQ-029 An ack arriving in the cycle the counter reaches TIMEOUT-1 SHALL win over the timeout.
REQ-030 A misaligned memory op in IDLE SHALL issue no request and no stall, pulse memFault on the next edge, and load a bubble.
REQ-031 In IDLE, a valid non-memory op SHALL load MEM/WB on the next edge, with valueToWB = result_EXMEM and regWrite_MEMWB = regWrite_EXMEM and (rd_EXMEM != 0); 1-cycle latency, no stall.
REQ-032 In IDLE with valid_EXMEM = 0, MEM/WB SHALL load a bubble.
REQ-033 memAck received in IDLE SHALL be ignored; this covers stray or late acks after an abort or reset.
REQ-034 memReq SHALL never be asserted in IDLE.

Reset
REQ-035 With reset high at an edge: FSM = IDLE, counter = 0, and all of the following = 0: memReq, memWe, memAddr, memWdata, regWrite_MEMWB, rd_MEMWB, valueToWB, memFault.
REQ-036 Reset SHALL take priority over every other event, including a pending memAck.
REQ-037 A BUSY transaction interrupted by reset SHALL be dropped, with memReq low from the first post-reset cycle and no writeback produced.
REQ-038 Reset SHALL force stallPipeline = 0.

Verification
REQ-039 Load, zero-wait: lw to rd = 5, address 0x100, memAck in the first BUSY cycle with memRdata = 0xDEADBEEF -> stall high for 1 cycle; regWrite_MEMWB = 1, rd_MEMWB = 5, valueToWB = 0xDEADBEEF two edges after accept.
REQ-040 Store, 3-cycle wait: sw to address 0x40 with data 0x12345678, ack on the 3rd BUSY cycle -> memReq/memWe high for 3 cycles at 0x40/0x12345678; stall low on the ack cycle; regWrite_MEMWB = 0.
REQ-041 Timeout: TIMEOUT = 4 with no ack -> memReq high for 4 cycles, one memFault pulse, a bubble in MEM/WB, FSM back in IDLE; a later stray ack produces no writeback.
REQ-042 Misaligned load: address 0x102 -> no memReq, no stall, memFault pulses on the next edge, regWrite_MEMWB = 0.
REQ-043 Back-to-back: ALU op to rd = 0 followed by an ALU op to rd = 3 with result 7 -> first cycle regWrite_MEMWB = 0; next cycle regWrite_MEMWB = 1, rd_MEMWB = 3, valueToWB = 7; no stall.
REQ-044 Reset mid-op: reset asserted during BUSY with ack in the same cycle -> all outputs zero, no writeback, memReq low afterwards.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives a request/ack data-memory port, stalls upstream while a
// transfer is pending, and feeds the MEM/WB latch plus the forwarding value.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_EXMEM,
  input  logic        memRead_EXMEM,
  input  logic        memWrite_EXMEM,
  input  logic        regWrite_EXMEM,
  input  logic        memToReg_EXMEM,
  input  logic [31:0] result_EXMEM,
  input  logic [31:0] writeData_EXMEM,
  input  logic [4:0]  rd_EXMEM,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        stallPipeline,
  output logic        regWrite_MEMWB,
  output logic [4:0]  rd_MEMWB,
  output logic [31:0] valueToWB,
  output logic        memFault
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [4:0]      rd_q;
  logic            we_q;
  logic            reg_write_q;
  logic            mem_to_reg_q;

  logic mem_op;
  logic aligned;
  logic busy;
  logic timeout_hit;

  assign mem_op      = valid_EXMEM && (memRead_EXMEM || memWrite_EXMEM);
  assign aligned     = (result_EXMEM[1:0] == 2'b00);
  assign busy        = (state_q == StBusy);
  assign timeout_hit = busy && (cnt_q == CntW'(TIMEOUT - 1));

  // Request side comes straight from state and the latched transaction, so it stays
  // stable for the whole BUSY period regardless of what EX/MEM presents.
  assign memReq   = busy;
  assign memWe    = busy && we_q;
  assign memAddr  = addr_q;
  assign memWdata = wdata_q;

  assign stallPipeline = !reset &&
                         ((!busy && mem_op && aligned) || (busy && !memAck && !timeout_hit));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_q           <= '0;
      we_q           <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      regWrite_MEMWB <= 1'b0;
      rd_MEMWB       <= '0;
      valueToWB      <= '0;
      memFault       <= 1'b0;
    end else begin
      // Every path loads a bubble unless it overrides below.
      memFault       <= 1'b0;
      regWrite_MEMWB <= 1'b0;
      rd_MEMWB       <= '0;
      valueToWB      <= '0;
      unique case (state_q)
        StIdle: begin
          if (mem_op && aligned) begin
            addr_q       <= result_EXMEM;
            wdata_q      <= writeData_EXMEM;
            rd_q         <= rd_EXMEM;
            we_q         <= memWrite_EXMEM;
            reg_write_q  <= regWrite_EXMEM;
            mem_to_reg_q <= memToReg_EXMEM;
            cnt_q        <= '0;
            state_q      <= StBusy;
          end else if (mem_op) begin
            memFault <= 1'b1;
          end else if (valid_EXMEM) begin
            regWrite_MEMWB <= regWrite_EXMEM && (rd_EXMEM != 5'd0);
            rd_MEMWB       <= rd_EXMEM;
            valueToWB      <= result_EXMEM;
          end
        end
        StBusy: begin
          // Ack is checked first so it wins over a simultaneous timeout.
          if (memAck) begin
            regWrite_MEMWB <= reg_write_q && (rd_q != 5'd0);
            rd_MEMWB       <= rd_q;
            valueToWB      <= mem_to_reg_q ? memRdata : addr_q;
            state_q        <= StIdle;
          end else if (timeout_hit) begin
            memFault <= 1'b1;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected MEM/WB events (writebacks and
// faults, stamped with the edge count they must appear at); a monitor pops and compares.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_EXMEM, memRead_EXMEM, memWrite_EXMEM, regWrite_EXMEM, memToReg_EXMEM;
  logic [31:0] result_EXMEM, writeData_EXMEM;
  logic [4:0]  rd_EXMEM;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic        memAck;
  logic [31:0] memRdata;
  logic        stallPipeline, regWrite_MEMWB;
  logic [4:0]  rd_MEMWB;
  logic [31:0] valueToWB;
  logic        memFault;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_EXMEM     (valid_EXMEM),
    .memRead_EXMEM   (memRead_EXMEM),
    .memWrite_EXMEM  (memWrite_EXMEM),
    .regWrite_EXMEM  (regWrite_EXMEM),
    .memToReg_EXMEM  (memToReg_EXMEM),
    .result_EXMEM    (result_EXMEM),
    .writeData_EXMEM (writeData_EXMEM),
    .rd_EXMEM        (rd_EXMEM),
    .memReq          (memReq),
    .memWe           (memWe),
    .memAddr         (memAddr),
    .memWdata        (memWdata),
    .memAck          (memAck),
    .memRdata        (memRdata),
    .stallPipeline   (stallPipeline),
    .regWrite_MEMWB  (regWrite_MEMWB),
    .rd_MEMWB        (rd_MEMWB),
    .valueToWB       (valueToWB),
    .memFault        (memFault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          fault;
    logic [4:0]  rd;
    logic [31:0] val;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit fault, input logic [4:0] rd, input logic [31:0] val,
                      input int at);
    ev_t e;
    e.fault = fault;
    e.rd    = rd;
    e.val   = val;
    e.cyc   = at;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic r, input logic w, input logic rw,
                       input logic m2r, input logic [31:0] res, input logic [31:0] wd,
                       input logic [4:0] rd);
    valid_EXMEM     = v;
    memRead_EXMEM   = r;
    memWrite_EXMEM  = w;
    regWrite_EXMEM  = rw;
    memToReg_EXMEM  = m2r;
    result_EXMEM    = res;
    writeData_EXMEM = wd;
    rd_EXMEM        = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 64'({memReq, memWe, regWrite_MEMWB, memFault, stallPipeline}), 64'd0);
    check({tag, "_req"}, {memAddr, memWdata}, 64'd0);
    check({tag, "_wb"}, 64'({rd_MEMWB, valueToWB}), 64'd0);
  endtask

  // Monitor: every writeback or fault pulse must match the oldest expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset && (regWrite_MEMWB || memFault)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: got regWrite=%0b fault=%0b rd=%0d val=%h at cycle %0d, expected none",
                   regWrite_MEMWB, memFault, rd_MEMWB, valueToWB, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.fault) begin
            check("fault_event", 64'({memFault, regWrite_MEMWB, cyc}),
                  64'({1'b1, 1'b0, e.cyc}));
          end else begin
            check("wb_timing", 64'({memFault, regWrite_MEMWB, cyc}), 64'({1'b0, 1'b1, e.cyc}));
            check("wb_data", 64'({rd_MEMWB, valueToWB}), 64'({e.rd, e.val}));
          end
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    memAck   = 1'b0;
    memRdata = 32'h0;
    idle();
    repeat (2) step();

    // A load presented during reset must not stall; outputs stay zero.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd5);
    @(negedge clk);
    check_zero("reset");
    step();
    reset = 1'b0;

    // Zero-wait load: accept edge, then ack in first BUSY cycle.
    push(1'b0, 5'd5, 32'hDEADBEEF, cyc + 2);
    @(negedge clk);
    check("lw_accept", 64'({memReq, stallPipeline}), 64'b01);
    step();
    idle();
    memAck   = 1'b1;
    memRdata = 32'hDEADBEEF;
    @(negedge clk);
    check("lw_busy", 64'({memReq, memWe, stallPipeline}), 64'b100);
    check("lw_addr", 64'(memAddr), 64'h100);
    step();
    memAck   = 1'b0;
    memRdata = 32'h0;
    @(negedge clk);
    check("lw_done_noreq", 64'(memReq), 64'd0);

    // Store with ack on the 3rd BUSY cycle; a distracting ALU op is presented meanwhile.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h12345678, 5'd0);
    @(negedge clk);
    check("sw_accept_stall", 64'(stallPipeline), 64'd1);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      memAck = (i == 2);
      @(negedge clk);
      check("sw_busy", 64'({memReq, memWe, stallPipeline}), 64'({1'b1, 1'b1, i != 2}));
      check("sw_req", {memAddr, memWdata}, {32'h40, 32'h12345678});
      step();
    end
    idle();
    memAck = 1'b0;
    @(negedge clk);
    check("sw_done_noreq", 64'(memReq), 64'd0);

    // Ack in the same cycle the counter hits TIMEOUT-1 wins.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 5'd8);
    push(1'b0, 5'd8, 32'h0BAD_F00D, cyc + 5);
    step();
    idle();
    memRdata = 32'h0BAD_F00D;
    for (int i = 0; i < 4; i++) begin
      memAck = (i == 3);
      @(negedge clk);
      check("late_ack_busy", 64'({memReq, stallPipeline}), 64'({1'b1, i != 3}));
      step();
    end
    memAck   = 1'b0;
    memRdata = 32'h0;

    // Timeout: four request cycles, one fault pulse, then a stray ack is ignored.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 5'd7);
    push(1'b1, 5'd0, 32'h0, cyc + 5);
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_busy", 64'({memReq, stallPipeline}), 64'({1'b1, i != 3}));
      step();
    end
    memAck   = 1'b1;
    memRdata = 32'h1111_1111;
    @(negedge clk);
    check("to_stray_ack", 64'({memReq, stallPipeline}), 64'd0);
    step();
    memAck   = 1'b0;
    memRdata = 32'h0;

    // Misaligned load: no request, no stall, fault on the next edge.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd4);
    push(1'b1, 5'd0, 32'h0, cyc + 1);
    @(negedge clk);
    check("mis_noreq", 64'({memReq, stallPipeline}), 64'd0);
    step();
    idle();
    @(negedge clk);
    check("mis_after", 64'(memReq), 64'd0);

    // Back-to-back ALU ops: rd=0 suppresses the write, rd=3 writes 7.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 5'd0);
    @(negedge clk);
    check("b2b_first_stall", 64'(stallPipeline), 64'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7, 32'h0, 5'd3);
    push(1'b0, 5'd3, 32'h7, cyc + 1);
    @(negedge clk);
    check("b2b_rd0_nowrite", 64'({regWrite_MEMWB, stallPipeline}), 64'd0);
    step();
    idle();

    // Reset during BUSY with a simultaneous ack drops the transaction.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd6);
    @(negedge clk);
    check("rst_accept_stall", 64'(stallPipeline), 64'd1);
    step();
    idle();
    memAck   = 1'b1;
    memRdata = 32'hCAFE_F00D;
    reset    = 1'b1;
    @(negedge clk);
    check("rst_busy_stall", 64'(stallPipeline), 64'd0);
    step();
    reset    = 1'b0;
    memAck   = 1'b0;
    memRdata = 32'h0;
    @(negedge clk);
    check_zero("rst_mid");
    step();
    @(negedge clk);
    check("rst_after_noreq", 64'(memReq), 64'd0);

    repeat (3) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
